pe_fusion_acc: RTL and testbench

PE_FUSION_ACC -- requirements
Module: pe_fusion_acc

---
 rtl/pe_fusion_acc.sv | 135 +++++++++++++
 tb/tb_pe_fusion_acc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_fusion_acc.sv
// rtl/pe_fusion_acc.sv - 2-bit sliced dot-product accumulator with shift; define PE_FUSION_SAT_EN to saturate instead of wrap
module pe_fusion_acc #(
  parameter int N_DOT    = 16,
  parameter int BITS_ACC = 24,
  parameter int BITS_SH  = 4
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [2*N_DOT-1:0]         i_act,
  input  logic [2*N_DOT-1:0]         i_weight,
  input  logic                       i_sign_w,
  input  logic [BITS_SH-1:0]         i_shift,
  input  logic                       i_last,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic signed [BITS_ACC-1:0] o_psum
);

  // Lane products span -6..9 (5 bits signed); the lane sum needs clog2(N_DOT) more bits.
  localparam int DOT_W = $clog2(N_DOT) + 5;

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic signed [BITS_ACC-1:0] acc_q, acc_d;
  logic signed [BITS_ACC-1:0] psum_q, psum_d;
  logic                       valid_q, valid_d;

  logic signed [DOT_W-1:0]    dot;
  logic signed [4:0]          lane_a, lane_w, lane_p;
  logic signed [BITS_ACC-1:0] base;
  logic signed [BITS_ACC-1:0] sum;
  logic                       accept;

  // Dot product over all lanes; weights are sign-extended only when i_sign_w marks an MSB slice.
  always_comb begin
    dot    = '0;
    lane_a = '0;
    lane_w = '0;
    lane_p = '0;
    for (int k = 0; k < N_DOT; k++) begin
      lane_a = {3'b000, i_act[2*k +: 2]};
      lane_w = i_sign_w ? {{3{i_weight[2*k+1]}}, i_weight[2*k +: 2]}
                        : {3'b000, i_weight[2*k +: 2]};
      lane_p = lane_a * lane_w;
      dot    = dot + DOT_W'(lane_p);
    end
  end

  // A beat in IDLE starts a fresh group, so it adds onto zero rather than the stale accumulator.
  always_comb begin
    base = (state_q == ACC) ? acc_q : '0;
  end

`ifdef PE_FUSION_SAT_EN
  // Wide enough that neither the shift nor the add can overflow before clamping.
  localparam int WIDE_W = BITS_ACC + DOT_W + (1 << BITS_SH) + 1;
  localparam logic signed [WIDE_W-1:0] SAT_MAX =
    {{(WIDE_W-BITS_ACC+1){1'b0}}, {(BITS_ACC-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [WIDE_W-1:0] term_w, sum_w;

  // Shift and add at full precision, then clamp into the accumulator range.
  always_comb begin
    term_w = WIDE_W'(dot) <<< i_shift;
    sum_w  = WIDE_W'(base) + term_w;
    if (sum_w > SAT_MAX) begin
      sum = BITS_ACC'(SAT_MAX);
    end else if (sum_w < SAT_MIN) begin
      sum = BITS_ACC'(SAT_MIN);
    end else begin
      sum = BITS_ACC'(sum_w);
    end
  end
`else
  logic signed [BITS_ACC-1:0] term;

  // Plain modulo-2^BITS_ACC arithmetic: bits shifted past the MSB are simply dropped.
  always_comb begin
    term = BITS_ACC'(dot) << i_shift;
    sum  = base + term;
  end
`endif

  // State register plus accumulator and result holding register.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      acc_q   <= '0;
      psum_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      psum_q  <= psum_d;
      valid_q <= valid_d;
    end
  end

  // Next state: a final beat closes the group, any other accepted beat keeps it open.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = i_last ? IDLE : ACC;
    end
  end

  // Handshake outputs: accept whenever the result slot is empty or being drained this cycle.
  always_comb begin
    o_ready = RSTN && (!valid_q || i_ready);
    accept  = i_valid && o_ready;
    o_valid = valid_q;
    o_psum  = psum_q;
  end

  // Datapath next values: accumulate on accepted beats, publish on the final one, drop valid on drain.
  always_comb begin
    acc_d   = acc_q;
    psum_d  = psum_q;
    valid_d = valid_q;
    if (accept) begin
      acc_d = sum;
    end
    if (accept && i_last) begin
      psum_d  = sum;
      valid_d = 1'b1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_fusion_acc.sv
// tb/tb_pe_fusion_acc.sv - scoreboard bench for pe_fusion_acc (N_DOT=16, BITS_ACC=12)
module tb_pe_fusion_acc;

  localparam int N  = 16;
  localparam int BA = 12;
  localparam int BS = 4;

  logic              CLK      = 1'b0;
  logic              RSTN     = 1'b0;
  logic              i_valid  = 1'b0;
  logic              i_sign_w = 1'b0;
  logic              i_last   = 1'b0;
  logic              i_ready  = 1'b1;
  logic [2*N-1:0]    i_act    = '0;
  logic [2*N-1:0]    i_weight = '0;
  logic [BS-1:0]     i_shift  = '0;
  logic              o_ready;
  logic              o_valid;
  logic signed [BA-1:0] o_psum;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int m_acc  = 0;
  bit m_open = 1'b0;
  bit m_valid = 1'b0;
  bit mon_en = 1'b0;

  pe_fusion_acc #(.N_DOT(N), .BITS_ACC(BA), .BITS_SH(BS)) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_act    (i_act),
    .i_weight (i_weight),
    .i_sign_w (i_sign_w),
    .i_shift  (i_shift),
    .i_last   (i_last),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_psum   (o_psum)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2*N-1:0] rep(input logic [1:0] v);
    return {N{v}};
  endfunction

  // Reference limiting of a running sum to the 12-bit result range.
  function automatic int lim(input longint x);
    longint m;
`ifdef PE_FUSION_SAT_EN
    if (x > 2047) return 2047;
    if (x < -2048) return -2048;
    return int'(x);
`else
    m = x & 64'hFFF;
    if (m >= 2048) m = m - 4096;
    return int'(m);
`endif
  endfunction

  // Reference shifted dot product of the beat currently on the inputs.
  function automatic longint beat_term();
    longint d = 0;
    longint a, w;
    for (int k = 0; k < N; k++) begin
      a = longint'(i_act[2*k +: 2]);
      w = longint'(i_weight[2*k +: 2]);
      if (i_sign_w && w >= 2) w = w - 4;
      d = d + a * w;
    end
    return d * (longint'(1) << i_shift);
  endfunction

  // Scoreboard monitor: checks outputs against the model state, then advances the model.
  always @(negedge CLK) begin
    bit     exp_ready;
    bit     acc_b;
    longint t;
    if (mon_en) begin
      exp_ready = RSTN && (!m_valid || i_ready);
      check("o_ready", int'(o_ready), int'(exp_ready));
      check("o_valid", int'(o_valid), int'(m_valid));
      if (m_valid) begin
        if (exp_q.size() > 0) check("o_psum", int'(o_psum), exp_q[0]);
        else check("sb_nonempty", exp_q.size(), 1);
      end
      if (!RSTN) begin
        m_valid = 1'b0;
        m_open  = 1'b0;
        m_acc   = 0;
        exp_q.delete();
      end else begin
        acc_b = i_valid && exp_ready;
        if (m_valid && i_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_valid = 1'b0;
        end
        if (acc_b) begin
          t = beat_term();
          m_acc = lim((m_open ? longint'(m_acc) : 0) + t);
          if (i_last) begin
            exp_q.push_back(m_acc);
            m_valid = 1'b1;
            m_open  = 1'b0;
          end else begin
            m_open = 1'b1;
          end
        end
      end
    end
  end

  // Offer one beat and hold it until accepted; returns at posedge+1 after acceptance.
  task automatic send(input logic [2*N-1:0] act, input logic [2*N-1:0] wt,
                      input bit sgn, input logic [BS-1:0] sh, input bit last);
    bit done = 1'b0;
    i_act    = act;
    i_weight = wt;
    i_sign_w = sgn;
    i_shift  = sh;
    i_last   = last;
    i_valid  = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge CLK);
      done = o_ready;
      @(posedge CLK);
      #1;
      if (!done) i_ready = 1'b1;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    check("beat_accepted", int'(done), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    RSTN     = 1'b0;
    i_valid  = 1'b1;
    i_last   = 1'b1;
    i_act    = rep(2'd3);
    i_weight = rep(2'd3);
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK);
      #1;
      mon_en = 1'b1;
      check("rst_o_valid", int'(o_valid), 0);
      check("rst_o_psum",  int'(o_psum),  0);
      check("rst_o_ready", int'(o_ready), 0);
    end
    RSTN    = 1'b1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    @(posedge CLK);
    #1;
    check("post_rst_no_result", int'(o_valid), 0);

    send(rep(2'd3), rep(2'd3), 1'b0, 4'd0, 1'b1);
    check("single_psum",  int'(o_psum),  144);
    check("single_valid", int'(o_valid), 1);

    send(rep(2'd1), rep(2'd3), 1'b0, 4'd0, 1'b0);
    send(rep(2'd1), rep(2'd2), 1'b1, 4'd2, 1'b1);
    check("signed_psum", int'(o_psum), -80);

    @(posedge CLK);
    #1;
    i_ready = 1'b0;
    send(rep(2'd3), rep(2'd3), 1'b0, 4'd0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check("hold_psum",  int'(o_psum),  144);
      check("hold_valid", int'(o_valid), 1);
      check("hold_ready", int'(o_ready), 0);
      @(posedge CLK);
      #1;
    end
    i_ready = 1'b1;
    send(rep(2'd1), rep(2'd1), 1'b0, 4'd0, 1'b1);
    check("swap_psum",  int'(o_psum),  16);
    check("swap_valid", int'(o_valid), 1);
    @(posedge CLK);
    #1;
    check("drain_valid", int'(o_valid), 0);

    send(rep(2'd3), rep(2'd3), 1'b0, 4'd6, 1'b1);
`ifdef PE_FUSION_SAT_EN
    check("overflow_psum", int'(o_psum), 2047);
`else
    check("overflow_psum", int'(o_psum), 1024);
`endif

    send(rep(2'd3), rep(2'd3), 1'b0, 4'd0, 1'b0);
    send(rep(2'd2), rep(2'd1), 1'b1, 4'd1, 1'b0);
    RSTN = 1'b0;
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    send(rep(2'd1), rep(2'd1), 1'b0, 4'd0, 1'b1);
    check("midrst_psum",  int'(o_psum),  16);
    check("midrst_valid", int'(o_valid), 1);

    for (int g = 0; g < 25; g++) begin
      nb = int'($urandom_range(1, 4));
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 2) == 0) begin
          @(posedge CLK);
          #1;
        end
        i_ready = 1'($urandom_range(0, 1));
        send($urandom, $urandom, 1'($urandom_range(0, 1)),
             BS'($urandom_range(0, 7)), b == nb - 1);
      end
    end
    i_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
